// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and fetch counter.
// Optional self-jump halt detection is enabled by defining HALT_DETECT_EN.
module fetch_unit (
  input  logic        clk,
  input  logic        resetBar,
  input  logic [7:0]  dbus,
  input  logic        loadBarIR,
  input  logic        doJump,
  output logic [7:0]  pc,
  output logic [7:0]  ir,
  output logic [7:0]  instrAddr,
  output logic [15:0] instrCount,
  output logic        halted
);

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    pc_nxt, ir_nxt, addr_nxt;
  logic [COUNT_W-1:0]   count_nxt;
  logic                 halted_nxt;

  // State and output registers; reset overrides everything, including HALT.
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state      <= RUN;
      pc         <= '0;
      ir         <= '0;
      instrAddr  <= '0;
      instrCount <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir         <= ir_nxt;
      instrAddr  <= addr_nxt;
      instrCount <= count_nxt;
      halted     <= halted_nxt;
    end
  end

  // Next-state and next-output logic; HALT simply holds every register.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    addr_nxt   = instrAddr;
    count_nxt  = instrCount;
    halted_nxt = 1'b0;
    case (state)
      RUN: begin
        pc_nxt = doJump ? dbus : pc + ADDR_W'(1);
        if (!loadBarIR) begin
          ir_nxt    = dbus;
          addr_nxt  = pc;
          count_nxt = instrCount + COUNT_W'(1);
        end
`ifdef HALT_DETECT_EN
        // A jump back to the address of the current instruction never progresses.
        if (doJump && (dbus == instrAddr)) begin
          state_nxt  = HALT;
          halted_nxt = 1'b1;
        end
`endif
      end
      HALT: begin
`ifdef HALT_DETECT_EN
        halted_nxt = 1'b1;
`else
        state_nxt  = RUN;
`endif
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations follow HALT_DETECT_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetBar;
  logic [7:0]  dbus;
  logic        loadBarIR;
  logic        doJump;
  logic [7:0]  pc, ir, instrAddr;
  logic [15:0] instrCount;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk        (clk),
    .resetBar   (resetBar),
    .dbus       (dbus),
    .loadBarIR  (loadBarIR),
    .doJump     (doJump),
    .pc         (pc),
    .ir         (ir),
    .instrAddr  (instrAddr),
    .instrCount (instrCount),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"}, 16'(pc), 16'h0000);
    check({tag, " ir"}, 16'(ir), 16'h0000);
    check({tag, " instrAddr"}, 16'(instrAddr), 16'h0000);
    check({tag, " instrCount"}, instrCount, 16'h0000);
    check({tag, " halted"}, 16'(halted), 16'h0000);
  endtask

  logic halt_en;

  initial begin
`ifdef HALT_DETECT_EN
    halt_en = 1'b1;
`else
    halt_en = 1'b0;
`endif
    resetBar = 1'b0; dbus = 8'h00; loadBarIR = 1'b1; doJump = 1'b0;
    step(); step();
    check_reset_values("reset");
    // Inputs active while reset is held must be ignored.
    loadBarIR = 1'b0; doJump = 1'b1; dbus = 8'h5A;
    step();
    check_reset_values("reset_hold");
    loadBarIR = 1'b1; doJump = 1'b0; dbus = 8'h00;

    resetBar = 1'b1;
    check("seq pc0", 16'(pc), 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("seq pc%0d", i), 16'(pc), 16'(i));
    end
    check("seq ir", 16'(ir), 16'h0000);
    check("seq count", instrCount, 16'h0000);

    doJump = 1'b1; dbus = 8'h10; step(); doJump = 1'b0;
    check("jump pc10", 16'(pc), 16'h0010);
    loadBarIR = 1'b0; dbus = 8'h2A; step(); loadBarIR = 1'b1;
    check("load ir", 16'(ir), 16'h002A);
    check("load instrAddr", 16'(instrAddr), 16'h0010);
    check("load pc", 16'(pc), 16'h0011);
    check("load count", instrCount, 16'h0001);

    doJump = 1'b1; dbus = 8'h20; step();
    dbus = 8'h05; step(); doJump = 1'b0;
    check("jump pc05", 16'(pc), 16'h0005);
    check("jump keeps ir", 16'(ir), 16'h002A);
    doJump = 1'b1; dbus = 8'hFF; step(); doJump = 1'b0;
    check("pc ff", 16'(pc), 16'h00FF);
    step();
    check("pc wrap", 16'(pc), 16'h0000);

    // Jump and load in the same cycle.
    doJump = 1'b1; loadBarIR = 1'b0; dbus = 8'h30; step();
    doJump = 1'b0; loadBarIR = 1'b1;
    check("both pc", 16'(pc), 16'h0030);
    check("both ir", 16'(ir), 16'h0030);
    check("both instrAddr", 16'(instrAddr), 16'h0000);
    check("both count", instrCount, 16'h0002);
    check("both halted", 16'(halted), 16'h0000);

    loadBarIR = 1'b0; dbus = 8'h77; step(); loadBarIR = 1'b1;
    check("pre self instrAddr", 16'(instrAddr), 16'h0030);
    check("pre self pc", 16'(pc), 16'h0031);

    // Self-jump.
    doJump = 1'b1; dbus = 8'h30; step(); doJump = 1'b0;
    check("self pc", 16'(pc), 16'h0030);
    check("self halted", 16'(halted), 16'(halt_en));
    loadBarIR = 1'b0; dbus = 8'h55; step(); loadBarIR = 1'b1;
    check("post load pc", 16'(pc), halt_en ? 16'h0030 : 16'h0031);
    check("post load ir", 16'(ir), halt_en ? 16'h0077 : 16'h0055);
    check("post load instrAddr", 16'(instrAddr), 16'h0030);
    check("post load count", instrCount, halt_en ? 16'h0003 : 16'h0004);
    doJump = 1'b1; dbus = 8'h99; step(); doJump = 1'b0;
    check("post jump pc", 16'(pc), halt_en ? 16'h0030 : 16'h0099);
    check("post jump halted", 16'(halted), 16'(halt_en));
    step();
    check("post idle pc", 16'(pc), halt_en ? 16'h0030 : 16'h009A);

    resetBar = 1'b0; step(); resetBar = 1'b1;
    check_reset_values("reset_halt");
    step();
    check("resume pc", 16'(pc), 16'h0001);

    loadBarIR = 1'b0;
    for (int i = 0; i < 16'h0123; i++) begin
      dbus = 8'(i); step();
    end
    loadBarIR = 1'b1;
    check("count 0123", instrCount, 16'h0123);
    resetBar = 1'b0; step(); resetBar = 1'b1;
    check_reset_values("reset_mid");

    loadBarIR = 1'b0; dbus = 8'hC3;
    for (int i = 0; i < 16'hFFFF; i++) step();
    loadBarIR = 1'b1;
    check("count ffff", instrCount, 16'hFFFF);
    loadBarIR = 1'b0; step(); loadBarIR = 1'b1;
    check("count wrap", instrCount, 16'h0000);
    check("wrap halted", 16'(halted), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
